eth_encap_mux: RTL

- Successor to the single-channel FIFO-to-MAC encapsulator: drains NUM_CH first-word-fall-through TLP tap FIFOs and wraps each TLP in its own Ethernet frame.
- Frames are emitted on one 64-bit AXI-Stream to the 10G MAC TX port.
- Each frame carries a 2-byte tag: source channel ID plus a per-channel 12-bit sequence number.
- Adds round-robin arbitration, a length cap with truncation, and a configurable inter-frame gap.

---
 rtl/eth_encap_mux.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_encap_mux.sv
// ---------------------------------------------------------------------------
// eth_encap_mux
//
// Drains NUM_CH first-word-fall-through TLP tap FIFOs and wraps each TLP in
// its own Ethernet frame on a single 64-bit AXI-Stream towards the 10G MAC.
// Channels are served round-robin, one arbitration per frame. Each frame
// carries a 2-byte tag {channel[3:0], seq[11:0]} with a per-channel 12-bit
// sequence number. Frames longer than MAX_BEATS payload beats are cut short
// (tlast+tuser on the last emitted beat) and the rest of the TLP is dropped.
// After every frame the output is held idle for IFG_CYCLES cycles.
//
// Optional feature (macro ETH_ENCAP_MUX_TIMESTAMP_EN): a free-running 64-bit
// cycle counter is sampled at the grant and sent as one extra beat after the
// second header beat.
//
// Ports:
//   clk156          in   clock
//   sys_rst         in   synchronous active-high reset
//   dout            in   NUM_CH x 74-bit FIFO heads: [63:0] data,
//                        [65:64] dword keep, [66] end of TLP, [73:67] unused
//   empty           in   per-channel FIFO empty
//   rd_en           out  per-channel FIFO pop
//   m_axis_tvalid   out  AXI-S valid
//   m_axis_tready   in   AXI-S ready
//   m_axis_tdata    out  AXI-S data, byte 0 in [7:0]
//   m_axis_tkeep    out  AXI-S byte keep
//   m_axis_tlast    out  AXI-S end of frame
//   m_axis_tuser    out  on the last beat, 1 = aborted/truncated frame
//   frame_cnt       out  frames completed (wraps)
//   trunc_cnt       out  frames truncated (saturates)
// ---------------------------------------------------------------------------
module eth_encap_mux #(
    parameter int          NUM_CH     = 4,
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0002_0304_0506,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          MAX_BEATS  = 64,
    parameter int          IFG_CYCLES = 8
) (
    input  logic                 clk156,
    input  logic                 sys_rst,
    input  logic [NUM_CH*74-1:0] dout,
    input  logic [NUM_CH-1:0]    empty,
    output logic [NUM_CH-1:0]    rd_en,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [31:0]          frame_cnt,
    output logic [15:0]          trunc_cnt
);

    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    // First header beat is constant: DST_MAC MSB first, then SRC_MAC[47:32].
    localparam logic [63:0] HDR0_WORD = {SRC_MAC[39:32], SRC_MAC[47:40],
                                         DST_MAC[7:0],   DST_MAC[15:8],
                                         DST_MAC[23:16], DST_MAC[31:24],
                                         DST_MAC[39:32], DST_MAC[47:40]};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
`ifdef ETH_ENCAP_MUX_TIMESTAMP_EN
        S_TS,
`endif
        S_PAYLOAD,
        S_DISCARD,
        S_GAP
    } state_t;

    // With no gap the frame end returns straight to arbitration.
    localparam state_t END_ST = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_last;
    logic [11:0]        r_seq [NUM_CH];
    logic [BEAT_W-1:0]  r_beat;
    logic [7:0]         r_gap;
    logic [31:0]        r_frame_cnt;
    logic [15:0]        r_trunc_cnt;
`ifdef ETH_ENCAP_MUX_TIMESTAMP_EN
    logic [63:0]        r_ts_cnt;
    logic [63:0]        r_ts_smp;
`endif

    logic               w_any;
    logic [SEL_W-1:0]   w_grant;
    int                 w_best_d;
    logic [73:0]        w_word;
    logic               w_empty_sel;
    logic [NUM_CH-1:0]  w_sel_oh;
    logic               w_eot;
    logic               w_cap;
    logic               w_hs;
    logic               w_unused;

    // Dword keep to byte keep; a zero keep means both dwords are valid.
    function automatic logic [7:0] f_keep(input logic [1:0] k);
        logic [1:0] kk;
        kk = (k == 2'b00) ? 2'b11 : k;
        return {{4{kk[1]}}, {4{kk[0]}}};
    endfunction

    // Round robin: the non-empty channel closest after the last grant wins.
    always_comb begin
        w_any    = 1'b0;
        w_grant  = r_last;
        w_best_d = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!empty[c] &&
                ((c - int'(r_last) - 1 + 2 * NUM_CH) % NUM_CH) < w_best_d) begin
                w_best_d = (c - int'(r_last) - 1 + 2 * NUM_CH) % NUM_CH;
                w_grant  = SEL_W'(c);
                w_any    = 1'b1;
            end
        end
    end

    // Head word and status of the selected channel.
    always_comb begin
        w_word      = '0;
        w_empty_sel = 1'b1;
        w_sel_oh    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_sel == SEL_W'(c)) begin
                w_word      = dout[74*c +: 74];
                w_empty_sel = empty[c];
                w_sel_oh[c] = 1'b1;
            end
        end
    end

    assign w_eot    = w_word[66];
    assign w_cap    = (r_beat == BEAT_W'(MAX_BEATS - 1));
    assign w_hs     = m_axis_tvalid && m_axis_tready;
    assign w_unused = ^w_word[73:67];

    // State register
    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_next = S_HDR0;
            S_HDR0:    if (w_hs)  w_next = S_HDR1;
`ifdef ETH_ENCAP_MUX_TIMESTAMP_EN
            S_HDR1:    if (w_hs)  w_next = S_TS;
            S_TS:      if (w_hs)  w_next = S_PAYLOAD;
`else
            S_HDR1:    if (w_hs)  w_next = S_PAYLOAD;
`endif
            S_PAYLOAD: begin
                if (w_hs) begin
                    if (w_eot)      w_next = END_ST;
                    else if (w_cap) w_next = S_DISCARD;
                end
            end
            S_DISCARD: if (!w_empty_sel && w_eot) w_next = END_ST;
            S_GAP:     if (r_gap == 8'(IFG_CYCLES - 1)) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic; every beat is a function of state and FIFO head only,
    // so it holds steady while the sink stalls.
    always_comb begin
        rd_en         = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (r_state)
            S_HDR0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = HDR0_WORD;
                m_axis_tkeep  = 8'hFF;
            end
            S_HDR1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {r_seq[r_sel][7:0], 4'(r_sel), r_seq[r_sel][11:8],
                                 ETHERTYPE[7:0], ETHERTYPE[15:8],
                                 SRC_MAC[7:0], SRC_MAC[15:8],
                                 SRC_MAC[23:16], SRC_MAC[31:24]};
                m_axis_tkeep  = 8'hFF;
            end
`ifdef ETH_ENCAP_MUX_TIMESTAMP_EN
            S_TS: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = r_ts_smp;
                m_axis_tkeep  = 8'hFF;
            end
`endif
            S_PAYLOAD: begin
                m_axis_tvalid = !w_empty_sel;
                m_axis_tdata  = w_word[63:0];
                m_axis_tkeep  = f_keep(w_word[65:64]);
                m_axis_tlast  = w_eot || w_cap;
                m_axis_tuser  = !w_eot && w_cap;
                rd_en         = w_sel_oh & {NUM_CH{!w_empty_sel && m_axis_tready}};
            end
            S_DISCARD: begin
                rd_en = w_sel_oh & {NUM_CH{!w_empty_sel}};
            end
            default: ;
        endcase
    end

    // Grant-time selection, not reset: only consulted after a grant.
    always_ff @(posedge clk156) begin
        if (r_state == S_IDLE && w_any) begin
            r_sel <= w_grant;
`ifdef ETH_ENCAP_MUX_TIMESTAMP_EN
            r_ts_smp <= r_ts_cnt;
`endif
        end
    end

    // Arbitration pointer, sequence numbers, beat/gap counters, statistics
    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            r_last      <= SEL_W'(NUM_CH - 1);
            r_beat      <= '0;
            r_gap       <= '0;
            r_frame_cnt <= '0;
            r_trunc_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) r_seq[c] <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_last <= w_grant;
                r_beat <= '0;
            end
            if (r_state == S_HDR1 && w_hs) begin
                r_seq[r_sel] <= r_seq[r_sel] + 12'd1;
            end
            if (r_state == S_PAYLOAD && w_hs) begin
                r_beat <= r_beat + BEAT_W'(1);
                if (w_eot || w_cap) r_frame_cnt <= r_frame_cnt + 32'd1;
                if (!w_eot && w_cap && r_trunc_cnt != 16'hFFFF)
                    r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
            r_gap <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
        end
    end

`ifdef ETH_ENCAP_MUX_TIMESTAMP_EN
    always_ff @(posedge clk156) begin
        if (sys_rst) r_ts_cnt <= '0;
        else         r_ts_cnt <= r_ts_cnt + 64'd1;
    end
`endif

    assign frame_cnt = r_frame_cnt;
    assign trunc_cnt = r_trunc_cnt;

endmodule
